// File: rtl/operand_mesh_router.sv
// operand_mesh_router: 5-port XY-routed mesh node. Each input has a FIFO, each
// output has a round-robin arbiter feeding a registered output stage.
// Ports: 0=N, 1=S, 2=E, 3=W, 4=Local. Flit = {dest_row, dest_col, payload}.
// Optional build macro OPND_ROUTER_STATS_EN adds per-output flit counters and
// an output-stall cycle counter.
module operand_mesh_router #(
    parameter int unsigned GRID_ROWS = 4,
    parameter int unsigned GRID_COLS = 4,
    parameter int unsigned ROW_ID    = 0,
    parameter int unsigned COL_ID    = 0,
    parameter int unsigned PAYLOAD_W = 48,
    parameter int unsigned BUF_DEPTH = 4,
    localparam int unsigned ROW_W    = $clog2(GRID_ROWS),
    localparam int unsigned COL_W    = $clog2(GRID_COLS),
    localparam int unsigned FLIT_W   = ROW_W + COL_W + PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        in_valid,
    input  logic [FLIT_W-1:0] in_flit [5],
    output logic [4:0]        in_ready,
    output logic [4:0]        out_valid,
    output logic [FLIT_W-1:0] out_flit [5],
    input  logic [4:0]        out_ready,
    output logic              err_misroute
`ifdef OPND_ROUTER_STATS_EN
    ,
    output logic [31:0]       stat_flits [5],
    output logic [31:0]       stat_stall
`endif
);

    localparam int unsigned NP    = 5;
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_S = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    localparam logic [ROW_W-1:0] MY_ROW = ROW_W'(ROW_ID);
    localparam logic [COL_W-1:0] MY_COL = COL_W'(COL_ID);

    // Edge nodes have no neighbour on the grid boundary side
    localparam bit HAS_N = (ROW_ID != 0);
    localparam bit HAS_S = (ROW_ID != GRID_ROWS - 1);
    localparam bit HAS_W = (COL_ID != 0);
    localparam bit HAS_E = (COL_ID != GRID_COLS - 1);

    logic [FLIT_W-1:0] mem_q      [NP][BUF_DEPTH];
    logic [FLIT_W-1:0] mem_d      [NP][BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q   [NP];
    logic [PTR_W-1:0]  wr_ptr_d   [NP];
    logic [PTR_W-1:0]  rd_ptr_q   [NP];
    logic [PTR_W-1:0]  rd_ptr_d   [NP];
    logic [CNT_W-1:0]  count_q    [NP];
    logic [CNT_W-1:0]  count_d    [NP];
    logic [4:0]        out_valid_q;
    logic [4:0]        out_valid_d;
    logic [FLIT_W-1:0] out_flit_q [NP];
    logic [FLIT_W-1:0] out_flit_d [NP];
    logic [2:0]        rr_q       [NP];
    logic [2:0]        rr_d       [NP];
    logic              err_q;
    logic              err_d;

    logic [FLIT_W-1:0] head_c     [NP];
    logic [2:0]        route_c    [NP];
    logic [4:0]        req_c;
    logic [4:0]        drop_c;
    logic [4:0]        pop_c;
    logic [4:0]        push_c;

    // Input handshake: ready depends only on the registered FIFO occupancy
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            in_ready[i] = (count_q[i] != CNT_W'(BUF_DEPTH));
        end
        push_c = in_valid & in_ready;
    end

    // XY route of each FIFO head; off-grid routes become drop requests
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            head_c[i]  = mem_q[i][rd_ptr_q[i]];
            route_c[i] = P_L;
            req_c[i]   = 1'b0;
            drop_c[i]  = 1'b0;
            if (head_c[i][PAYLOAD_W +: COL_W] > MY_COL) begin
                route_c[i] = P_E;
                drop_c[i]  = !HAS_E;
            end else if (head_c[i][PAYLOAD_W +: COL_W] < MY_COL) begin
                route_c[i] = P_W;
                drop_c[i]  = !HAS_W;
            end else if (head_c[i][PAYLOAD_W + COL_W +: ROW_W] > MY_ROW) begin
                route_c[i] = P_S;
                drop_c[i]  = !HAS_S;
            end else if (head_c[i][PAYLOAD_W + COL_W +: ROW_W] < MY_ROW) begin
                route_c[i] = P_N;
                drop_c[i]  = !HAS_N;
            end
            if (count_q[i] == '0) begin
                drop_c[i] = 1'b0;
            end else begin
                req_c[i] = !drop_c[i];
            end
        end
    end

    // Per-output round-robin arbitration and output register load/drain
    always_comb begin
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        out_valid_d = out_valid_q & ~out_ready;
        out_flit_d  = out_flit_q;
        rr_d        = rr_q;
        pop_c       = drop_c;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            found = 1'b0;
            if (!out_valid_q[o] || out_ready[o]) begin
                for (int unsigned k = 0; k < NP; k++) begin
                    sum = {1'b0, rr_q[o]} + 4'(k);
                    idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                    if (!found && req_c[idx] && (route_c[idx] == 3'(o))) begin
                        found          = 1'b1;
                        out_valid_d[o] = 1'b1;
                        out_flit_d[o]  = head_c[idx];
                        pop_c[idx]     = 1'b1;
                        rr_d[o]        = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                    end
                end
            end
        end
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (|drop_c);
        for (int unsigned i = 0; i < NP; i++) begin
            if (push_c[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_flit[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop_c[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            count_d[i] = count_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NP; i++) begin
                for (int unsigned d = 0; d < BUF_DEPTH; d++) begin
                    mem_q[i][d] <= '0;
                end
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                out_flit_q[i] <= '0;
                rr_q[i]       <= '0;
            end
            out_valid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_flit_q  <= out_flit_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_flit     = out_flit_q;
    assign err_misroute = err_q;

`ifdef OPND_ROUTER_STATS_EN
    logic [31:0] stat_flits_q [NP];
    logic [31:0] stat_flits_d [NP];
    logic [31:0] stat_stall_q;
    logic [31:0] stat_stall_d;

    // Delivered-flit and stalled-cycle counters, free-running wrap
    always_comb begin
        for (int unsigned o = 0; o < NP; o++) begin
            stat_flits_d[o] = stat_flits_q[o] + 32'(out_valid_q[o] & out_ready[o]);
        end
        stat_stall_d = stat_stall_q + 32'(|(out_valid_q & ~out_ready));
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < NP; o++) begin
                stat_flits_q[o] <= '0;
            end
            stat_stall_q <= '0;
        end else begin
            stat_flits_q <= stat_flits_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_flits = stat_flits_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_operand_mesh_router.sv
// Testbench for operand_mesh_router: a 4x4 node at (1,1) checked through a
// per-output scoreboard, plus a 3x3 node at (0,2) for off-grid drops.
`timescale 1ns/1ps
module tb_operand_mesh_router;

    localparam int unsigned FW = 52;
    typedef logic [FW-1:0] flit_t;
    localparam int PN = 0;
    localparam int PS = 1;
    localparam int PE = 2;
    localparam int PW = 3;
    localparam int PL = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_e_n;
    always #5 clk = ~clk;

    logic [4:0] in_valid, in_ready, out_valid, out_ready;
    flit_t      in_flit [5];
    flit_t      out_flit [5];
    logic       err;
    logic [4:0] e_in_valid, e_in_ready, e_out_valid, e_out_ready;
    flit_t      e_in_flit [5];
    flit_t      e_out_flit [5];
    logic       e_err;
`ifdef OPND_ROUTER_STATS_EN
    logic [31:0] stat_flits [5];
    logic [31:0] stat_stall;
    logic [31:0] e_stat_flits [5];
    logic [31:0] e_stat_stall;
`endif

    operand_mesh_router #(
        .GRID_ROWS(4), .GRID_COLS(4), .ROW_ID(1), .COL_ID(1),
        .PAYLOAD_W(48), .BUF_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
        .err_misroute(err)
`ifdef OPND_ROUTER_STATS_EN
        , .stat_flits(stat_flits), .stat_stall(stat_stall)
`endif
    );

    operand_mesh_router #(
        .GRID_ROWS(3), .GRID_COLS(3), .ROW_ID(0), .COL_ID(2),
        .PAYLOAD_W(48), .BUF_DEPTH(4)
    ) dut_e (
        .clk(clk), .rst_n(rst_e_n),
        .in_valid(e_in_valid), .in_flit(e_in_flit), .in_ready(e_in_ready),
        .out_valid(e_out_valid), .out_flit(e_out_flit), .out_ready(e_out_ready),
        .err_misroute(e_err)
`ifdef OPND_ROUTER_STATS_EN
        , .stat_flits(e_stat_flits), .stat_stall(e_stat_stall)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    flit_t exp_q [5][$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flit = {dest_row[1:0], dest_col[1:0], src[2:0], seq[44:0]}
    function automatic flit_t mk(input int row, input int col, input int src, input int seq);
        return {2'(row), 2'(col), 3'(src), 45'(seq)};
    endfunction

    // XY reference route for the node at (1,1)
    function automatic int xy_port(input flit_t f);
        logic [1:0] dr;
        logic [1:0] dc;
        dr = f[51:50];
        dc = f[49:48];
        if (dc > 2'd1) return PE;
        if (dc < 2'd1) return PW;
        if (dr > 2'd1) return PS;
        if (dr < 2'd1) return PN;
        return PL;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one flit and hold it until accepted; main-node flits go on the scoreboard
    task automatic send(input bit to_e, input int p, input flit_t f);
        int n = 0;
        if (to_e) begin
            e_in_valid[p] = 1'b1;
            e_in_flit[p]  = f;
        end else begin
            in_valid[p] = 1'b1;
            in_flit[p]  = f;
        end
        @(negedge clk);
        while (!(to_e ? e_in_ready[p] : in_ready[p]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("send_timeout", 64'(to_e ? e_in_ready[p] : in_ready[p]), 64'(1));
        end else if (!to_e) begin
            exp_q[xy_port(f)].push_back(f);
        end
        @(posedge clk);
        #1;
        if (to_e) e_in_valid[p] = 1'b0;
        else      in_valid[p]   = 1'b0;
    endtask

    // Scoreboard: match each delivered flit against the oldest one from the same source
    always @(negedge clk) begin
        int hit;
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    hit = -1;
                    for (int j = 0; j < exp_q[o].size(); j++) begin
                        if (hit < 0 && exp_q[o][j][47:45] == out_flit[o][47:45]) hit = j;
                    end
                    check($sformatf("sb_expected_p%0d", o), 64'(hit >= 0), 64'(1));
                    if (hit >= 0) begin
                        check($sformatf("sb_flit_p%0d", o), 64'(out_flit[o]), 64'(exp_q[o][hit]));
                        exp_q[o].delete(hit);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        flit_t f, fn, fw, fl;
        flit_t fs [5];
        int    rp;
        bit    rand_done;

        in_valid = '0;  out_ready = 5'h1f;
        e_in_valid = '0; e_out_ready = 5'h1f;
        for (int i = 0; i < 5; i++) begin
            in_flit[i]   = '0;
            e_in_flit[i] = '0;
        end
        rst_n = 1'b0;
        rst_e_n = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_out_flit_e", 64'(out_flit[PE]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        rst_e_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(5'h1f));
        check("post_rst_e_err", 64'(e_err), 64'(0));

        // Local -> East with zero contention: visible one edge after acceptance
        f = mk(1, 3, PL, 1);
        send(0, PL, f);
        check("lat_edge_k", 64'(out_valid[PE]), 64'(0));
        @(posedge clk);
        #1;
        check("lat_edge_k1_valid", 64'(out_valid[PE]), 64'(1));
        check("lat_edge_k1_flit", 64'(out_flit[PE]), 64'(f));
        idle(3);

        // N, W, Local contend for Local from a fresh pointer
        fn = mk(1, 1, PN, 2);
        fw = mk(1, 1, PW, 3);
        fl = mk(1, 1, PL, 4);
        in_valid[PN] = 1'b1; in_flit[PN] = fn;
        in_valid[PW] = 1'b1; in_flit[PW] = fw;
        in_valid[PL] = 1'b1; in_flit[PL] = fl;
        exp_q[PL].push_back(fn);
        exp_q[PL].push_back(fw);
        exp_q[PL].push_back(fl);
        @(posedge clk);
        #1;
        in_valid = '0;
        @(posedge clk); #1;
        check("rr_1st", 64'(out_flit[PL]), 64'(fn));
        @(posedge clk); #1;
        check("rr_2nd", 64'(out_flit[PL]), 64'(fw));
        @(posedge clk); #1;
        check("rr_3rd", 64'(out_flit[PL]), 64'(fl));
        check("rr_3rd_valid", 64'(out_valid[PL]), 64'(1));
        idle(3);

        // Backpressure on South: 4 buffered plus 1 held in the output register
        out_ready[PS] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            fs[s] = mk(3, 1, PN, 10 + s);
            send(0, PN, fs[s]);
        end
        check("bp_in_ready_n", 64'(in_ready[PN]), 64'(0));
        check("bp_out_valid_s", 64'(out_valid[PS]), 64'(1));
        check("bp_hold_0", 64'(out_flit[PS]), 64'(fs[0]));
        for (int s = 0; s < 3; s++) begin
            idle(1);
            check("bp_hold", 64'(out_flit[PS]), 64'(fs[0]));
        end
        out_ready[PS] = 1'b1;
        idle(8);
        check("bp_drained", 64'(exp_q[PS].size()), 64'(0));

        // Off-grid route at the east edge of a 3x3 grid is dropped and sticky
        send(1, PW, mk(0, 3, PW, 50));
        @(posedge clk); #1;
        check("mis_err", 64'(e_err), 64'(1));
        check("mis_in_ready", 64'(e_in_ready[PW]), 64'(1));
        check("mis_no_out", 64'(e_out_valid), 64'(0));
        f = mk(0, 2, PW, 51);
        send(1, PW, f);
        @(posedge clk); #1;
        check("mis_next_local_valid", 64'(e_out_valid[PL]), 64'(1));
        check("mis_next_local_flit", 64'(e_out_flit[PL]), 64'(f));
        check("mis_sticky", 64'(e_err), 64'(1));
        idle(2);
        check("mis_sticky_later", 64'(e_err), 64'(1));
        rst_e_n = 1'b0;
        #1;
        check("mis_cleared_by_rst", 64'(e_err), 64'(0));
        @(negedge clk);
        rst_e_n = 1'b1;
        idle(1);

        // Random traffic with random output backpressure
        fork
            begin : rand_src
                for (int r = 0; r < 40; r++) begin
                    rp = int'($urandom_range(0, 4));
                    send(0, rp, mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rp, 100 + r));
                end
                rand_done = 1'b1;
            end
            begin : rand_rdy
                for (int c = 0; c < 3000 && !rand_done; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 5'($urandom);
                end
            end
        join
        out_ready = 5'h1f;
        idle(20);
        for (int o = 0; o < 5; o++) begin
            check($sformatf("rand_drained_p%0d", o), 64'(exp_q[o].size()), 64'(0));
        end
        check("rand_no_err", 64'(err), 64'(0));

        // Reset mid-stream with three flits sitting in the East-bound FIFO
        out_ready = '0;
        for (int s = 0; s < 4; s++) send(0, PL, mk(1, 3, PL, 200 + s));
        check("rst_mid_pre_valid", 64'(out_valid[PE]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async_valid", 64'(out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(5'h1f));
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 5'h1f;
        @(posedge clk); #1;
        check("rst_rel_in_ready", 64'(in_ready), 64'(5'h1f));
        idle(6);
        check("rst_rel_empty", 64'(out_valid), 64'(0));

`ifdef OPND_ROUTER_STATS_EN
        // Ten flits out East with exactly two stalled cycles
        check("stat_flits_rst", 64'(stat_flits[PE]), 64'(0));
        check("stat_stall_rst", 64'(stat_stall), 64'(0));
        out_ready[PE] = 1'b0;
        fork
            begin : st_src
                for (int s = 0; s < 10; s++) send(0, PL, mk(1, 3, PL, 300 + s));
            end
            begin : st_rdy
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid[PE] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready[PE] = 1'b1;
            end
        join
        idle(10);
        check("stat_flits_e", 64'(stat_flits[PE]), 64'(10));
        check("stat_stall", 64'(stat_stall), 64'(2));
        check("stat_drained", 64'(exp_q[PE].size()), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
